// File: rtl/cache_axi_pkg.sv
// cache_axi_pkg: shared burst constants, IDs and FSM state types for the cache AXI arbiter
package cache_axi_pkg;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_DONE} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} wr_state_e;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B = 3'b010;
  localparam logic [7:0] LEN_LINE = 8'd7;
  localparam logic [3:0] ID_ICACHE = 4'd0;
  localparam logic [3:0] ID_DCACHE = 4'd1;
  localparam int LINE_W = 256;
  localparam int WORDS = 8;
endpackage

// File: rtl/line_writeback_fsm.sv
// line_writeback_fsm: AXI write channel sequencer for one 8-beat DCache line writeback
module line_writeback_fsm
  import cache_axi_pkg::*;
(
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              dc_wr_req,
  input  logic [26:0]       dc_wr_line,
  input  logic [LINE_W-1:0] dc_wr_data,
  output logic              dc_wr_done,
  output logic [3:0]        awid,
  output logic [31:0]       awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready,
  output logic              busy,
  output logic [26:0]       wr_line
);
  wr_state_e         state;
  logic [2:0]        k;
  logic [LINE_W-1:0] data;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state   <= W_IDLE;
      k       <= '0;
      wr_line <= '0;
      data    <= '0;
    end else
      case (state)
        W_IDLE: if (dc_wr_req) begin
          state   <= W_AW;
          k       <= '0;
          wr_line <= dc_wr_line;
          data    <= dc_wr_data;
        end
        W_AW:   if (awready) state <= W_DATA;
        W_DATA: if (wready) begin
          k <= k + 3'd1;
          if (k == 3'd7) state <= W_B;
        end
        W_B:    if (bvalid) state <= W_IDLE;
        default: state <= W_IDLE;
      endcase
  assign awid       = ID_DCACHE;
  assign awaddr     = {wr_line, 5'b0};
  assign awlen      = LEN_LINE;
  assign awsize     = SIZE_4B;
  assign awburst    = BURST_INCR;
  assign awvalid    = state == W_AW;
  assign wvalid     = state == W_DATA;
  assign wdata      = data[{k, 5'b0} +: 32];
  assign wstrb      = 4'hF;
  assign wlast      = wvalid && k == 3'd7;
  assign bready     = state == W_B;
  assign dc_wr_done = bready && bvalid;
  assign busy       = state != W_IDLE;
endmodule

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: shares one AXI4 master between ICache refill, DCache refill and DCache writeback
module cache_axi_arbiter
  import cache_axi_pkg::*;
(
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              ic_rd_req,
  input  logic [31:0]       ic_rd_addr,
  output logic              ic_ret_valid,
  output logic [LINE_W-1:0] ic_ret_data,
  input  logic              dc_rd_req,
  input  logic [31:0]       dc_rd_addr,
  output logic              dc_ret_valid,
  output logic [LINE_W-1:0] dc_ret_data,
  input  logic              dc_wr_req,
  input  logic [31:0]       dc_wr_addr,
  input  logic [LINE_W-1:0] dc_wr_data,
  output logic              dc_wr_done,
  output logic [3:0]        arid,
  output logic [31:0]       araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic              rlast,
  input  logic              rvalid,
  input  logic [3:0]        rid,
  input  logic [1:0]        rresp,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [31:0]       awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  input  logic [1:0]        bresp,
  output logic              bready
);
  rd_state_e         rs;
  logic              owner;
  logic [26:0]       rline;
  logic [2:0]        rk;
  logic [LINE_W-1:0] rbuf;
  logic              w_busy;
  logic [26:0]       w_line;
  logic              dc_go;
  logic              unused_ok;
  assign unused_ok = ^{rid, rresp, bresp, ic_rd_addr[4:0], dc_rd_addr[4:0], dc_wr_addr[4:0]};
  // a refill must not overtake a writeback of the same line still in flight
  assign dc_go = dc_rd_req && !(w_busy && w_line == dc_rd_addr[31:5]);
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      rs    <= R_IDLE;
      owner <= 1'b0;
      rline <= '0;
      rk    <= '0;
      rbuf  <= '0;
    end else
      case (rs)
        R_IDLE: if (dc_go || ic_rd_req) begin
          rs    <= R_AR;
          owner <= dc_go;
          rline <= dc_go ? dc_rd_addr[31:5] : ic_rd_addr[31:5];
          rk    <= '0;
        end
        R_AR:   if (arready) rs <= R_DATA;
        R_DATA: if (rvalid) begin
          rbuf[{rk, 5'b0} +: 32] <= rdata;
          rk <= rk + 3'd1;
          if (rlast) rs <= R_DONE;
        end
        R_DONE: rs <= R_IDLE;
        default: rs <= R_IDLE;
      endcase
  assign arid         = owner ? ID_DCACHE : ID_ICACHE;
  assign araddr       = {rline, 5'b0};
  assign arlen        = LEN_LINE;
  assign arsize       = SIZE_4B;
  assign arburst      = BURST_INCR;
  assign arvalid      = rs == R_AR;
  assign rready       = rs == R_DATA;
  assign ic_ret_valid = rs == R_DONE && !owner;
  assign dc_ret_valid = rs == R_DONE && owner;
  assign ic_ret_data  = rbuf;
  assign dc_ret_data  = rbuf;
  line_writeback_fsm u_wb (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .dc_wr_req  (dc_wr_req),
    .dc_wr_line (dc_wr_addr[31:5]),
    .dc_wr_data (dc_wr_data),
    .dc_wr_done (dc_wr_done),
    .awid       (awid),
    .awaddr     (awaddr),
    .awlen      (awlen),
    .awsize     (awsize),
    .awburst    (awburst),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wlast      (wlast),
    .wvalid     (wvalid),
    .wready     (wready),
    .bvalid     (bvalid),
    .bready     (bready),
    .busy       (w_busy),
    .wr_line    (w_line)
  );
endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb_cache_axi_arbiter: directed self-checking bench for the cache AXI arbiter
module tb_cache_axi_arbiter;
  logic aclk, aresetn;
  logic ic_rd_req, dc_rd_req, dc_wr_req;
  logic [31:0] ic_rd_addr, dc_rd_addr, dc_wr_addr;
  logic [255:0] dc_wr_data, ic_ret_data, dc_ret_data;
  logic ic_ret_valid, dc_ret_valid, dc_wr_done;
  logic [3:0] arid, awid, rid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0] wstrb;
  int checks, errors, cyc;
  int ar_hs, ic_rets, dc_rets, wr_dones, wbeats, ic_ret_at, dc_ret_at, done_at;
  logic [3:0] ar_id [64];
  int ar_at [64];
  logic [31:0] wb_data [64];
  logic wb_last [64];

  cache_axi_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_ret_valid(ic_ret_valid), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_ret_valid(dc_ret_valid), .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data), .dc_wr_done(dc_wr_done),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rid(rid), .rresp(rresp), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (arvalid && arready) begin
      ar_id[ar_hs % 64] = arid;
      ar_at[ar_hs % 64] = cyc;
      ar_hs++;
    end
    if (wvalid && wready) begin
      wb_data[wbeats % 64] = wdata;
      wb_last[wbeats % 64] = wlast;
      wbeats++;
    end
    if (ic_ret_valid) begin ic_rets++; ic_ret_at = cyc; end
    if (dc_ret_valid) begin dc_rets++; dc_ret_at = cyc; end
    if (dc_wr_done) begin wr_dones++; done_at = cyc; end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] line_of(input logic [31:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = b + i;
    return r;
  endfunction

  task automatic rd_slave(input int hold, input logic [31:0] exp_addr, input logic [3:0] exp_id, input logic [31:0] base);
    int t = 0;
    logic [31:0] a0;
    while (!arvalid && t < 40) begin step(); t++; end
    chk("ar_req", {arvalid, araddr, arid, arlen, arsize, arburst}, {1'b1, exp_addr, exp_id, 8'd7, 3'b010, 2'b01});
    a0 = araddr;
    repeat (hold) begin
      step();
      chk("ar_stable", {arvalid, araddr}, {1'b1, a0});
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rvalid = 1'b1;
      rdata  = base + i;
      rlast  = (i == 7);
      #1 chk("rready", rready, 1'b1);
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic wr_slave(input logic alt, input logic [31:0] exp_addr);
    int t = 0;
    int n = 0;
    while (!awvalid && t < 40) begin step(); t++; end
    chk("aw_req", {awvalid, awaddr, awid, awlen, awsize, awburst}, {1'b1, exp_addr, 4'd1, 8'd7, 3'b010, 2'b01});
    awready = 1'b1;
    step();
    awready = 1'b0;
    t = 0;
    while (n < 8 && t < 60) begin
      wready = !alt || (t % 2 == 0);
      if (wready && wvalid) n++;
      step();
      t++;
    end
    wready = 1'b0;
    chk("w_beats", n, 8);
    t = 0;
    while (!bready && t < 40) begin step(); t++; end
    chk("b_wait", {bready, dc_wr_done}, 2'b10);
    bvalid = 1'b1;
    #1 chk("b_done", dc_wr_done, 1'b1);
    step();
    bvalid    = 1'b0;
    dc_wr_req = 1'b0;
  endtask

  initial begin
    int c0, s, sw, sd;
    aresetn = 1'b0;
    {ic_rd_req, dc_rd_req, dc_wr_req, arready, rvalid, rlast, awready, wready, bvalid} = '0;
    ic_rd_addr = '0; dc_rd_addr = '0; dc_wr_addr = '0; dc_wr_data = '0;
    rdata = '0; rid = '0; rresp = '0; bresp = '0;
    step(); step();
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready, ic_ret_valid, dc_ret_valid, dc_wr_done}, 8'h00);
    chk("rst_addr", {araddr, awaddr}, 64'h0);
    chk("rst_data", ic_ret_data, 256'h0);
    aresetn = 1'b1;
    step();

    // ICache refill with cycle-exact latency
    ic_rd_req = 1'b1; ic_rd_addr = 32'h1C00_0044; c0 = cyc;
    rd_slave(0, 32'h1C00_0040, 4'd0, 32'h0);
    chk("ic_latency", cyc - c0, 10);
    chk("ic_pulse", {ic_ret_valid, dc_ret_valid}, 2'b10);
    chk("ic_data", ic_ret_data, line_of(32'h0));
    ic_rd_req = 1'b0;
    step();
    chk("ic_one_shot", {ic_ret_valid, dc_rets}, {1'b0, 32'd0});

    // simultaneous ic and dc refills: dc first
    s = ar_hs;
    ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_9000;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h0000_8000;
    rd_slave(0, 32'h0000_8000, 4'd1, 32'h100);
    chk("dc_first", {dc_ret_valid, ic_ret_valid}, 2'b10);
    chk("dc_data", dc_ret_data, line_of(32'h100));
    dc_rd_req = 1'b0;
    rd_slave(0, 32'h0000_9000, 4'd0, 32'h200);
    chk("ic_second", {ic_ret_valid, dc_ret_valid}, 2'b10);
    chk("ic2_data", ic_ret_data, line_of(32'h200));
    ic_rd_req = 1'b0;
    step();
    chk("two_ar", ar_hs - s, 2);
    chk("first_arid", ar_id[s % 64], 4'd1);
    chk("ret_order", dc_ret_at < ic_ret_at, 1'b1);

    // writeback with alternating wready
    sw = wbeats; sd = wr_dones;
    dc_wr_req = 1'b1; dc_wr_addr = 32'h0000_1000; dc_wr_data = line_of(32'hA0);
    wr_slave(1'b1, 32'h0000_1000);
    step();
    for (int i = 0; i < 8; i++) chk("w_word", {wb_data[(sw + i) % 64], wb_last[(sw + i) % 64]}, {32'hA0 + i, i == 7});
    chk("w_count", wbeats - sw, 8);
    chk("done_once", wr_dones - sd, 1);

    // same-line refill waits for the writeback; ic refill goes at once
    s = ar_hs;
    fork
      begin
        dc_wr_req = 1'b1; dc_wr_addr = 32'h0000_2000; dc_wr_data = line_of(32'hB0);
        wr_slave(1'b0, 32'h0000_2000);
      end
      begin
        step();
        dc_rd_req = 1'b1; dc_rd_addr = 32'h0000_2010;
        ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_3000; c0 = cyc;
        rd_slave(0, 32'h0000_3000, 4'd0, 32'h300);
        chk("conc_ic", {ic_ret_valid, ic_ret_data}, {1'b1, line_of(32'h300)});
        ic_rd_req = 1'b0;
        rd_slave(0, 32'h0000_2000, 4'd1, 32'h400);
        chk("conc_dc", {dc_ret_valid, dc_ret_data}, {1'b1, line_of(32'h400)});
        dc_rd_req = 1'b0;
      end
    join
    step();
    chk("ic_at_once", ar_at[s % 64] - c0, 1);
    chk("dc_after_done", ar_at[(s + 1) % 64] > done_at, 1'b1);

    // arready stalled for 5 cycles
    ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_6000;
    rd_slave(5, 32'h0000_6000, 4'd0, 32'h600);
    chk("stall_data", {ic_ret_valid, ic_ret_data}, {1'b1, line_of(32'h600)});
    ic_rd_req = 1'b0;
    step();

    // reset in the middle of a burst
    ic_rd_req = 1'b1; ic_rd_addr = 32'h4000_0000;
    step();
    arready = 1'b1;
    step();
    arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1; rdata = 32'hDEAD_0000 + i;
      step();
    end
    aresetn = 1'b0;
    #1 chk("mid_rst_valids", {arvalid, rready, awvalid, wvalid, bready, ic_ret_valid, dc_ret_valid, dc_wr_done}, 8'h00);
    chk("mid_rst_state", {araddr, ic_ret_data}, 288'h0);
    rvalid = 1'b0; ic_rd_req = 1'b0;
    s = ic_rets;
    step(); step();
    aresetn = 1'b1;
    step();
    ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_5000;
    rd_slave(0, 32'h0000_5000, 4'd0, 32'h500);
    chk("post_rst", {ic_ret_valid, ic_ret_data}, {1'b1, line_of(32'h500)});
    ic_rd_req = 1'b0;
    step();
    chk("no_stale", ic_rets - s, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
